// File: rtl/riscv_pkg.sv
// riscv_pkg: shared decode-stage definitions.
//   IMM_I..IMM_U : immsrc encodings for the immediate formats (101-111 illegal)
//   xlen_legal() : elaboration-time check for the supported datapath widths
package riscv_pkg;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  function automatic bit xlen_legal(input int xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/imm_decode.sv
// imm_decode: combinational RISC-V immediate decoder.
//   instr   [31:7]   instruction bits 31..7
//   immsrc  [2:0]    format select (I/S/B/J/U, others illegal)
//   immext  [XLEN-1:0] sign-extended immediate (0 when illegal)
//   illegal          immsrc is not a known format
module imm_decode
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]     instr,
  input  logic [2:0]      immsrc,
  output logic [XLEN-1:0] immext,
  output logic            illegal
);

  logic signed [31:0] imm32;

  // Every legal format places instr[31] at bit 31 of the 32-bit result,
  // so widening to 64 bits is a plain signed extension of imm32.
  always_comb begin
    imm32   = '0;
    illegal = 1'b0;
    case (immsrc)
      IMM_I: imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_U: imm32 = {instr[31:12], 12'b0};
      default: illegal = 1'b1;
    endcase
  end

  assign immext = XLEN'(imm32);

endmodule

// File: rtl/extend_pipe.sv
// extend_pipe: pipelined immediate generator with a 2-entry skid buffer.
//   clk, reset          clock, synchronous active-high reset
//   instr, immsrc,
//   in_tag, in_valid,
//   in_ready            input beat handshake (in_ready is registered)
//   immext, out_tag,
//   illegal, out_valid,
//   out_ready           output beat handshake, fields from the head entry
module extend_pipe
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:7]      instr,
  input  logic [2:0]       immsrc,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [XLEN-1:0]  immext,
  output logic [TAG_W-1:0] out_tag,
  output logic             illegal,
  output logic             out_valid,
  input  logic             out_ready
);

  if (!xlen_legal(XLEN)) begin : g_bad_xlen
    $error("extend_pipe: XLEN must be 32 or 64");
  end

  logic [XLEN-1:0]  dec_imm;
  logic             dec_ill;

  imm_decode #(.XLEN(XLEN)) u_dec (
    .instr   (instr),
    .immsrc  (immsrc),
    .immext  (dec_imm),
    .illegal (dec_ill)
  );

  logic [XLEN-1:0]  buf_imm [2];
  logic [TAG_W-1:0] buf_tag [2];
  logic             buf_ill [2];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       count;
  logic [1:0]       count_next;
  logic             in_ready_q;
  logic             acc;
  logic             del;

  assign in_ready  = in_ready_q;
  assign out_valid = (count != 2'd0);
  assign immext    = buf_imm[rd_ptr];
  assign out_tag   = buf_tag[rd_ptr];
  assign illegal   = buf_ill[rd_ptr];

  always_comb begin
    acc        = in_valid && in_ready_q;
    del        = out_valid && out_ready;
    count_next = count + {1'b0, acc} - {1'b0, del};
  end

  // in_ready_q is a registered copy of (count < 2), so nothing from
  // out_ready reaches in_ready combinationally.
  always_ff @(posedge clk) begin
    if (reset) begin
      count      <= 2'd0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      in_ready_q <= 1'b1;
      for (int i = 0; i < 2; i++) begin
        buf_imm[i] <= '0;
        buf_tag[i] <= '0;
        buf_ill[i] <= 1'b0;
      end
    end else begin
      if (acc) begin
        buf_imm[wr_ptr] <= dec_imm;
        buf_tag[wr_ptr] <= in_tag;
        buf_ill[wr_ptr] <= dec_ill;
        wr_ptr          <= ~wr_ptr;
      end
      if (del) begin
        rd_ptr <= ~rd_ptr;
      end
      count      <= count_next;
      in_ready_q <= (count_next < 2'd2);
    end
  end

endmodule

// File: tb/tb_extend_pipe.sv
module tb_extend_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] w32 = '0;
  logic [2:0]  src32 = '0;
  logic [4:0]  tag32 = '0;
  logic        iv32 = 1'b0;
  logic        ir32;
  logic [31:0] imm32;
  logic [4:0]  otag32;
  logic        ill32;
  logic        ov32;
  logic        or32 = 1'b1;

  logic [31:0] w64 = '0;
  logic [2:0]  src64 = '0;
  logic [4:0]  tag64 = '0;
  logic        iv64 = 1'b0;
  logic        ir64;
  logic [63:0] imm64;
  logic [4:0]  otag64;
  logic        ill64;
  logic        ov64;

  always #5 clk = ~clk;

  extend_pipe #(.XLEN(32), .TAG_W(5)) dut32 (
    .clk(clk), .reset(reset), .instr(w32[31:7]), .immsrc(src32), .in_tag(tag32),
    .in_valid(iv32), .in_ready(ir32), .immext(imm32), .out_tag(otag32),
    .illegal(ill32), .out_valid(ov32), .out_ready(or32)
  );

  extend_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
    .clk(clk), .reset(reset), .instr(w64[31:7]), .immsrc(src64), .in_tag(tag64),
    .in_valid(iv64), .in_ready(ir64), .immext(imm64), .out_tag(otag64),
    .illegal(ill64), .out_valid(ov64), .out_ready(1'b1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference decode from the format rules, in 64-bit arithmetic.
  function automatic logic [63:0] ref_imm(input logic [31:0] w, input logic [2:0] src);
    longint sw = longint'($signed(w));
    longint u  = longint'({32'b0, w});
    case (src)
      3'd0: return sw >>> 20;
      3'd1: return ((sw >>> 25) << 5) | ((u >> 7) & 31);
      3'd2: return ((sw >>> 31) << 12) | (((u >> 7) & 1) << 11) |
                   (((u >> 25) & 63) << 5) | (((u >> 8) & 15) << 1);
      3'd3: return ((sw >>> 31) << 20) | (((u >> 12) & 255) << 12) |
                   (((u >> 20) & 1) << 11) | (((u >> 21) & 1023) << 1);
      3'd4: return sw & ~longint'(4095);
      default: return 64'd0;
    endcase
  endfunction

  typedef struct {
    logic [31:0] imm;
    logic [4:0]  tag;
    logic        ill;
  } beat_t;

  beat_t q[$];
  beat_t nb;
  bit    armed = 0;
  bit    zero_expect = 0;
  int    accepted = 0;
  int    delivered = 0;
  bit    m_acc;
  bit    m_del;

  // Model of the 32-bit instance: a FIFO of capacity 2.
  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      armed = 1;
      zero_expect = 1;
    end else if (armed) begin
      m_acc = iv32 && (q.size() < 2);
      m_del = (q.size() != 0) && or32;
      if (m_del) begin
        void'(q.pop_front());
        delivered++;
      end
      if (m_acc) begin
        nb.imm = ref_imm(w32, src32)[31:0];
        nb.tag = tag32;
        nb.ill = (src32 > 3'd4);
        q.push_back(nb);
        accepted++;
        zero_expect = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (armed && !reset) begin
      chk("out_valid", 64'(ov32), 64'(q.size() != 0));
      chk("in_ready", 64'(ir32), 64'(q.size() < 2));
      if (q.size() != 0) begin
        chk("immext", 64'(imm32), 64'(q[0].imm));
        chk("out_tag", 64'(otag32), 64'(q[0].tag));
        chk("illegal", 64'(ill32), 64'(q[0].ill));
      end else if (zero_expect) begin
        chk("rst_immext", 64'(imm32), 64'd0);
        chk("rst_out_tag", 64'(otag32), 64'd0);
        chk("rst_illegal", 64'(ill32), 64'd0);
      end
    end
  end

  logic [31:0] vec_w   [5] = '{32'h12345678, 32'h9ABCDEF0, 32'hFEDCBA09, 32'h87654321, 32'h12345678};
  logic [31:0] vec_exp [5] = '{32'h00000123, 32'hFFFFF9BD, 32'hFFFFF7F4, 32'hFFF54076, 32'h12345000};

  int acc_lit;
  int start_acc;
  int n;

  initial begin
    // pin the reference model to hand-computed values
    for (int i = 0; i < 5; i++)
      chk($sformatf("model_vec%0d", i), ref_imm(vec_w[i], 3'(i)), {{32{vec_exp[i][31]}}, vec_exp[i]});
    chk("model_illegal", ref_imm(32'hFFFFFFFF, 3'd7), 64'd0);

    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    chk("reset_in_ready", 64'(ir32), 64'd1);
    chk("reset_out_valid", 64'(ov32), 64'd0);

    // back-to-back directed beats, out_ready held high
    for (int i = 0; i < 5; i++) begin
      w32 = vec_w[i]; src32 = 3'(i); tag32 = 5'(i + 10); iv32 = 1'b1;
      @(negedge clk);
      chk($sformatf("direct_imm%0d", i), 64'(imm32), 64'(vec_exp[i]));
      chk($sformatf("direct_tag%0d", i), 64'(otag32), 64'(i + 10));
    end

    // illegal select delivered, not dropped
    w32 = 32'hDEADBEEF; src32 = 3'b111; tag32 = 5'd7;
    @(negedge clk);
    iv32 = 1'b0;
    chk("illegal_valid", 64'(ov32), 64'd1);
    chk("illegal_imm", 64'(imm32), 64'd0);
    chk("illegal_flag", 64'(ill32), 64'd1);
    chk("illegal_tag", 64'(otag32), 64'd7);
    @(negedge clk);

    // XLEN=64 instance
    w64 = 32'hFEDCBA09; src64 = 3'd2; tag64 = 5'd3; iv64 = 1'b1;
    @(negedge clk);
    chk("x64_b", imm64, 64'hFFFFFFFFFFFFF7F4);
    chk("x64_b_valid", 64'(ov64), 64'd1);
    w64 = 32'h87654321; src64 = 3'd4; tag64 = 5'd4;
    @(negedge clk);
    chk("x64_u", imm64, 64'hFFFFFFFF87654000);
    chk("x64_u_tag", 64'(otag64), 64'd4);
    iv64 = 1'b0;
    @(negedge clk);

    // backpressure: 4 stalled cycles from empty accept exactly 2 beats
    or32 = 1'b0; iv32 = 1'b1; acc_lit = 0;
    for (int i = 0; i < 4; i++) begin
      w32 = $urandom; src32 = 3'($urandom_range(0, 4)); tag32 = 5'(20 + i);
      if (ir32) acc_lit++;
      @(negedge clk);
    end
    chk("stall_accepts", 64'(acc_lit), 64'd2);
    chk("stall_in_ready", 64'(ir32), 64'd0);
    iv32 = 1'b0; or32 = 1'b1;
    @(negedge clk);
    chk("release_in_ready", 64'(ir32), 64'd1);
    chk("release_tag", 64'(otag32), 64'd21);
    @(negedge clk);
    chk("drained", 64'(ov32), 64'd0);

    // reset while full
    or32 = 1'b0; iv32 = 1'b1; tag32 = 5'd30;
    n = 0;
    while (ir32 && n < 10) begin @(negedge clk); n++; end
    chk("full_before_reset", 64'(ov32 && !ir32), 64'd1);
    reset = 1'b1; tag32 = 5'd31;
    @(negedge clk);
    reset = 1'b0; iv32 = 1'b0; or32 = 1'b1;
    chk("post_reset_in_ready", 64'(ir32), 64'd1);
    chk("post_reset_out_valid", 64'(ov32), 64'd0);
    chk("post_reset_imm", 64'(imm32), 64'd0);
    repeat (3) @(negedge clk);

    // randomised traffic
    start_acc = accepted;
    n = 0;
    while (accepted - start_acc < 1000 && n < 20000) begin
      iv32 = 1'($urandom_range(0, 1));
      or32 = ($urandom_range(0, 3) != 0);
      w32 = $urandom; src32 = 3'($urandom_range(0, 7)); tag32 = 5'($urandom);
      @(negedge clk);
      n++;
    end
    chk("random_budget", 64'(accepted - start_acc >= 1000), 64'd1);
    iv32 = 1'b0; or32 = 1'b1;
    repeat (3) @(negedge clk);
    chk("final_empty", 64'(q.size()), 64'd0);
    chk("final_out_valid", 64'(ov32), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/extend_pipe.md
# extend_pipe

Pipelined, parametrised immediate generator for the RISC-V decode stage. It supersedes the purely combinational `extend` block in three ways: it decodes all five immediate formats (I/S/B/J/U), sign-extends to a configurable XLEN, and carries a user tag. Instructions enter and results leave through independent valid/ready handshakes, with a registered 2-entry skid buffer that decouples decode from downstream stalls.

## Interface
- `XLEN`, default 32: output width; legal values are 32 or 64.
- `TAG_W`, default 5: width of the opaque tag (e.g. rd index) carried alongside each immediate.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `reset` input, 1 bit: synchronous, active-high reset.
- `instr` input, 25 bits [31:7]: instruction bits 31..7.
- `immsrc` input, 3 bits: format select; 000 I, 001 S, 010 B, 011 J, 100 U, 101–111 illegal.
- `in_tag` input, TAG_W bits: tag accompanying `instr`.
- `in_valid` input, 1 bit: the input beat is valid.
- `in_ready` output, 1 bit: the block accepts a beat this cycle. Driven from a register.
- `immext` output, XLEN bits: extended immediate.
- `out_tag` output, TAG_W bits: tag of the current output beat.
- `illegal` output, 1 bit: the current output beat had an illegal `immsrc`.
- `out_valid` output, 1 bit: the output beat is valid.
- `out_ready` input, 1 bit: the consumer accepts the output beat.

## Operation
- A beat is accepted when `in_valid && in_ready` is high. It leaves when `out_valid && out_ready` is high.
- Decode is combinational on the input side; the decoded result is registered into the buffer. s = `instr[31]` replicated as needed to reach XLEN.
  - I: {s, instr[31:20]}
  - S: {s, instr[31:25], instr[11:7]}
  - B: {s, instr[7], instr[30:25], instr[11:8], 0}
  - J: {s, instr[19:12], instr[20], instr[30:21], 0}
  - U: {s(XLEN>32 only), instr[31:12], 12'b0}
  - Illegal select: `immext` = 0, `illegal` = 1. The beat is still accepted and delivered, never dropped.
- Buffer: 2 entries (main + skid), FIFO order, with an occupancy count of 0..2.
  - `out_valid` = (count != 0). The output fields come from the head entry.
  - `in_ready` is registered and equals (count_next < 2), i.e. (count < 2) after the update.
  - Accept and deliver in the same cycle: count is unchanged, head advances, and the new beat takes the tail slot.
  - Full (count = 2): `in_ready` = 0. An `in_valid` asserted while `in_ready` is low is ignored and does not need to be held stable by this block.
  - Empty: `out_valid` = 0. Output fields hold their last values and are don't-care.
- Reset (synchronous, at any time including mid-transfer):
  - Count goes to 0, so all buffered beats are discarded.
  - `out_valid` = 0, `in_ready` = 1 on the cycle after the reset edge.
  - `immext` = 0, `out_tag` = 0, `illegal` = 0.
  - While `reset` is high, no beats are accepted, regardless of the `in_ready` value shown.

## Timing
- Latency is 1 cycle: a beat accepted at edge N appears on the output after edge N with `out_valid` = 1, provided the buffer was empty.
- Throughput is 1 beat/cycle while `out_ready` stays high.
- Stall: if `out_ready` drops, one more beat is accepted (into skid), then `in_ready` falls on the next edge.
- Release: the first cycle with `out_ready` = 1 delivers the head. `in_ready` rises on the following edge. No bubbles are inserted while both sides are ready.
- There are no combinational paths from `out_ready` to `in_ready`, or from inputs to outputs.

## Structure
- Shared package `riscv_pkg` holds:
  - `immsrc` encoding constants IMM_I/IMM_S/IMM_B/IMM_J/IMM_U.
  - The legal-XLEN check constant.
- Sub-module `imm_decode`: a combinational format decoder (`instr`, `immsrc` → `immext`, `illegal`), parametrised by XLEN. It is reusable by the single-cycle core.
- Top level: the skid buffer, count, and handshake logic. An elaboration-time check rejects XLEN ∉ {32, 64}.

## Test plan
1. XLEN=32, `out_ready` held at 1, back-to-back beats:
   - `0x12345678`/I → `0x00000123`
   - `0x9ABCDEF0`/S → `0xFFFFF9BD`
   - `0xFEDCBA09`/B → `0xFFFFF7F4`
   - `0x87654321`/J → `0xFFF54076`
   - `0x12345678`/U → `0x12345000`

   Each result appears 1 cycle after acceptance, with no bubbles, and tags are preserved in order.
2. XLEN=64: `0xFEDCBA09`/B → `0xFFFFFFFFFFFFF7F4`; `0x87654321`/U → `0xFFFFFFFF87654000`.
3. `immsrc`=111 with tag 7 → delivered as `immext`=0, `illegal`=1, `out_tag`=7.
4. Backpressure:
   - Drop `out_ready` for 4 cycles with `in_valid` held high. Exactly 2 beats are accepted, and `in_ready` = 0 from the cycle after the second acceptance.
   - Raise `out_ready`: beats drain in order, and `in_ready` returns high 1 cycle later.
5. Assert `reset` for 1 cycle while count = 2. Next cycle: `out_valid`=0, `in_ready`=1, outputs zero, and none of the buffered beats ever appears on the output.
6. Randomised `in_valid`/`out_ready`, 1000 beats, checked against a reference model:
   - No loss, no duplication, order preserved.
   - `in_ready` never high while count = 2.
